regfile_param: RTL and testbench

//  Parametrised successor register file for the single-cycle/pipelined CPU datapath.
//  - Two asynchronous read ports and one synchronous write port.
//  - Width and depth are configurable.
//  - Optional hardwired-zero entry 0.
//  - A sequential clear engine zeroes every entry, one per cycle, after reset or on request.
//  - Reports busy while clearing and flags writes that are dropped.

---
 rtl/regfile_param.sv | 97 +++++++++
 tb/tb_regfile_param.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parametrised register file: two async read ports, one sync write port, sequential clear engine.
// Optional build macro REGFILE_BYPASS_EN turns on write-first forwarding to the read ports.
module regfile_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = (1 << ADDR_W),
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   output logic              busy,
   output logic              wr_drop
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr_ok;
   logic              fwd1;
   logic              fwd2;

   // Entry is backed by storage and not the hardwired zero register.
   function automatic logic addr_live(input logic [ADDR_W-1:0] a);
      return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   // Masking (busy, out-of-range, zero entry) wins over forwarding.
   function automatic logic [DATA_W-1:0] read_mux(
      input logic              is_busy,
      input logic [ADDR_W-1:0] ra,
      input logic              fwd,
      input logic [DATA_W-1:0] fwd_data,
      input logic [DATA_W-1:0] stored
   );
      if (is_busy || !addr_live(ra)) return '0;
      if (fwd) return fwd_data;
      return stored;
   endfunction

   assign busy  = (state == CLEAR);
   assign wr_ok = (state == IDLE) && we && !clr && !rst && addr_live(waddr);

`ifdef REGFILE_BYPASS_EN
   assign fwd1 = wr_ok && (raddr1 == waddr);
   assign fwd2 = wr_ok && (raddr2 == waddr);
`else
   assign fwd1 = 1'b0;
   assign fwd2 = 1'b0;
`endif

   assign rdata1 = read_mux(busy, raddr1, fwd1, wdata, mem[raddr1]);
   assign rdata2 = read_mux(busy, raddr2, fwd2, wdata, mem[raddr2]);

   // Control: sweep FSM, pointer and drop flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         ptr     <= '0;
         wr_drop <= 1'b0;
      end else begin
         wr_drop <= we && (busy || clr);
         if (clr) begin
            state <= CLEAR;
            ptr   <= '0;
         end else if (state == CLEAR) begin
            if (ptr == LAST) begin
               state <= IDLE;
               ptr   <= '0;
            end else begin
               ptr <= ptr + 1'b1;
            end
         end
      end
   end

   // Storage: the sweep owns the array while clearing, otherwise accepted writes land.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[ptr] <= '0;
      end else if (wr_ok) begin
         mem[waddr] <= wdata;
      end
   end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param (DEPTH=32, ZERO_REG=1); read expectations flow through a scoreboard queue.
module tb_regfile_param;

   logic        clk = 1'b0;
   logic        rst, clr, we;
   logic [4:0]  waddr, raddr1, raddr2;
   logic [31:0] wdata;
   logic [31:0] rdata1, rdata2;
   logic        busy, wr_drop;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] sb [$];

   regfile_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
      .busy(busy), .wr_drop(wr_drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected read data are queued with the addresses, then popped against the ports.
   task automatic rd(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [31:0] e1, input logic [31:0] e2);
      raddr1 = a1;
      raddr2 = a2;
      sb.push_back(e1);
      sb.push_back(e2);
      #1;
      chk({tag, "_p1"}, rdata1, sb.pop_front());
      chk({tag, "_p2"}, rdata2, sb.pop_front());
   endtask

   // Counts cycles with busy high, starting at the next falling edge; bounded.
   task automatic count_busy(input bit chk_rd, output int n);
      n = 0;
      @(negedge clk);
      while (busy === 1'b1 && n < 500) begin
         if (chk_rd) chk("sweep_rd0", rdata1, 32'h0);
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      logic [31:0] hz;
      rst = 1'b1; clr = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
      raddr1 = 5'd5; raddr2 = 5'd0;

      // Reset sweep: 32 busy cycles, reads masked, then all entries zero.
      tick();
      rst = 1'b0;
      chk("rst_busy", busy, 1'b1);
      chk("rst_drop", wr_drop, 1'b0);
      count_busy(1'b1, n);
      chk("rst_len", n, 32);
      for (int a = 0; a < 32; a += 2)
         rd("clear_all", 5'(a), 5'(a + 1), 32'h0, 32'h0);

      // Plain write then read.
      tick();
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
      tick();
      we = 1'b0;
      rd("wr5", 5'd5, 5'd0, 32'hDEADBEEF, 32'h0);
      chk("wr5_drop", wr_drop, 1'b0);

      // Zero register ignores writes silently.
      we = 1'b1; waddr = 5'd0; wdata = 32'h1234;
      tick();
      we = 1'b0;
      rd("zero", 5'd0, 5'd5, 32'h0, 32'hDEADBEEF);
      chk("zero_drop", wr_drop, 1'b0);

      // Same-cycle write/read hazard.
      we = 1'b1; waddr = 5'd7; wdata = 32'h1;
      tick();
      wdata = 32'hA5A5A5A5;
`ifdef REGFILE_BYPASS_EN
      hz = 32'hA5A5A5A5;
`else
      hz = 32'h1;
`endif
      rd("hazard", 5'd7, 5'd7, hz, hz);
      tick();
      waddr = 5'd0; wdata = 32'hFFFF;
      rd("zero_byp", 5'd0, 5'd7, 32'h0, 32'hA5A5A5A5);
      tick();
      we = 1'b0;
      rd("after_hz", 5'd7, 5'd5, 32'hA5A5A5A5, 32'hDEADBEEF);

      // Write dropped while busy; busy masks reads over forwarding.
      chk("idle_busy", busy, 1'b0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_busy", busy, 1'b1);
      we = 1'b1; waddr = 5'd3; wdata = 32'h33;
      rd("busy_mask", 5'd3, 5'd5, 32'h0, 32'h0);
      tick();
      we = 1'b0;
      chk("busy_drop1", wr_drop, 1'b1);
      tick();
      chk("busy_drop0", wr_drop, 1'b0);
      count_busy(1'b0, n);
      chk("clr_len", n, 30);
      rd("post_clr", 5'd3, 5'd5, 32'h0, 32'h0);
      rd("post_clr7", 5'd7, 5'd1, 32'h0, 32'h0);

      // clr restart at sweep cycle 10; write together with clr is dropped.
      tick();
      clr = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h44;
      tick();
      clr = 1'b0; we = 1'b0;
      chk("clr_we_drop", wr_drop, 1'b1);
      for (int i = 0; i < 10; i++) tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      count_busy(1'b0, n);
      chk("restart_clr_len", 11 + n, 43);

      // rst mid-sweep behaves the same.
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_drop", wr_drop, 1'b0);
      count_busy(1'b0, n);
      chk("restart_rst_len", 11 + n, 43);

      // Normal operation resumes.
      tick();
      we = 1'b1; waddr = 5'd31; wdata = 32'hCAFEF00D;
      tick();
      we = 1'b0;
      rd("final", 5'd31, 5'd4, 32'hCAFEF00D, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
